// File: rtl/encaps_if.sv
// rtl/encaps_if.sv - control bundle between the encapsulation sequencer and its datapath
interface encaps_if;
   logic       start;
   logic       rng_valid;
   logic       rng_ready;
   logic       fifo1_en;
   logic       pack_clr;
   logic [2:0] pack_idx;
   logic       fifo2_shift;
   logic       fifo2_clr;
   logic       hash_init;
   logic       hash_absorb;
   logic       keccak_done;
   logic       last_blk;
   logic [1:0] blk_idx;
   logic       k_load;
   logic       busy;
   logic       done;

   modport master (
      input  start, rng_valid, keccak_done,
      output rng_ready, fifo1_en, pack_clr, pack_idx, fifo2_shift, fifo2_clr,
             hash_init, hash_absorb, last_blk, blk_idx, k_load, busy, done
   );

   modport slave (
      output start, rng_valid, keccak_done,
      input  rng_ready, fifo1_en, pack_clr, pack_idx, fifo2_shift, fifo2_clr,
             hash_init, hash_absorb, last_blk, blk_idx, k_load, busy, done
   );
endinterface

// File: rtl/encaps_sequencer.sv
// rtl/encaps_sequencer.sv - NTRU-HRSS encapsulation control FSM: RNG fill, packing, SHA3 block scheduling
module encaps_sequencer #(
   parameter int RATE_WORDS  = 68,
   parameter int FULL_BLOCKS = 2,
   parameter int LAST_WORDS  = 4,
   parameter int PACK_BEATS  = 5
) (
   input logic       clk,
   input logic       ovr_rst1,
   encaps_if.master  ctl
);
   localparam int WCW = $clog2(RATE_WORDS + 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_INIT   = 3'd1;
   localparam logic [2:0] S_FILL   = 3'd2;
   localparam logic [2:0] S_FLUSH  = 3'd3;
   localparam logic [2:0] S_ABSORB = 3'd4;
   localparam logic [2:0] S_WAIT   = 3'd5;
   localparam logic [2:0] S_FINISH = 3'd6;

   localparam logic [2:0]     PACK_LAST = 3'(PACK_BEATS - 1);
   localparam logic [1:0]     BLK_LAST  = 2'(FULL_BLOCKS);
   localparam logic [WCW-1:0] RATE_LAST = WCW'(RATE_WORDS - 1);
   localparam logic [WCW-1:0] TAIL_LAST = WCW'(LAST_WORDS - 1);

   logic [2:0]     state_q, state_d;
   logic [2:0]     pack_idx_q, pack_idx_d;
   logic [WCW-1:0] word_cnt_q, word_cnt_d;
   logic [1:0]     blk_idx_q, blk_idx_d;

   logic rng_ready_q, pack_clr_q, fifo2_shift_q, fifo2_clr_q, hash_init_q;
   logic hash_absorb_q, last_blk_q, k_load_q, busy_q, done_q;

   logic accept, word_done, blk_final, fill_end, kdone;

   // rng_ready_q is only ever high in FILL, so acceptance needs no state decode
   assign accept    = ctl.rng_valid & rng_ready_q;
   assign word_done = accept & (pack_idx_q == PACK_LAST);
   assign blk_final = (blk_idx_q == BLK_LAST);
   assign fill_end  = word_done & (word_cnt_q == (blk_final ? TAIL_LAST : RATE_LAST));
   assign kdone     = (state_q == S_WAIT) & ctl.keccak_done;

   always_comb begin
      state_d    = state_q;
      pack_idx_d = pack_idx_q;
      word_cnt_d = word_cnt_q;
      blk_idx_d  = blk_idx_q;
      case (state_q)
         S_IDLE: begin
            if (ctl.start) state_d = S_INIT;
         end
         S_INIT: begin
            pack_idx_d = '0;
            word_cnt_d = '0;
            blk_idx_d  = '0;
            state_d    = S_FILL;
         end
         S_FILL: begin
            if (accept)    pack_idx_d = word_done ? 3'd0 : pack_idx_q + 3'd1;
            if (word_done) word_cnt_d = word_cnt_q + WCW'(1);
            if (fill_end)  state_d    = S_FLUSH;
         end
         S_FLUSH:  state_d = S_ABSORB;
         S_ABSORB: state_d = S_WAIT;
         S_WAIT: begin
            if (kdone) begin
               if (blk_final) begin
                  state_d = S_FINISH;
               end else begin
                  blk_idx_d  = blk_idx_q + 2'd1;
                  word_cnt_d = '0;
                  state_d    = S_FILL;
               end
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they line up with the state they belong to
   always_ff @(posedge clk or posedge ovr_rst1) begin
      if (ovr_rst1) begin
         state_q       <= S_IDLE;
         pack_idx_q    <= '0;
         word_cnt_q    <= '0;
         blk_idx_q     <= '0;
         rng_ready_q   <= 1'b0;
         pack_clr_q    <= 1'b0;
         fifo2_shift_q <= 1'b0;
         fifo2_clr_q   <= 1'b0;
         hash_init_q   <= 1'b0;
         hash_absorb_q <= 1'b0;
         last_blk_q    <= 1'b0;
         k_load_q      <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         pack_idx_q    <= pack_idx_d;
         word_cnt_q    <= word_cnt_d;
         blk_idx_q     <= blk_idx_d;
         rng_ready_q   <= (state_d == S_FILL);
         pack_clr_q    <= (state_d == S_INIT);
         hash_init_q   <= (state_d == S_INIT);
         fifo2_clr_q   <= (state_d == S_INIT) | (kdone & ~blk_final);
         fifo2_shift_q <= word_done;
         hash_absorb_q <= (state_d == S_ABSORB);
         last_blk_q    <= ((state_d == S_ABSORB) & blk_final) |
                          (last_blk_q & ((state_d == S_WAIT) | (state_d == S_FINISH)));
         k_load_q      <= (state_d == S_FINISH);
         done_q        <= (state_d == S_FINISH);
         busy_q        <= (state_d != S_IDLE);
      end
   end

   assign ctl.rng_ready   = rng_ready_q;
   assign ctl.fifo1_en    = accept;
   assign ctl.pack_clr    = pack_clr_q;
   assign ctl.pack_idx    = pack_idx_q;
   assign ctl.fifo2_shift = fifo2_shift_q;
   assign ctl.fifo2_clr   = fifo2_clr_q;
   assign ctl.hash_init   = hash_init_q;
   assign ctl.hash_absorb = hash_absorb_q;
   assign ctl.last_blk    = last_blk_q;
   assign ctl.blk_idx     = blk_idx_q;
   assign ctl.k_load      = k_load_q;
   assign ctl.busy        = busy_q;
   assign ctl.done        = done_q;
endmodule

// File: tb/tb_encaps_sequencer.sv
// tb/tb_encaps_sequencer.sv - scoreboard bench for encaps_sequencer
module tb_encaps_sequencer;
   logic clk = 1'b0;
   logic ovr_rst1 = 1'b1;
   always #5 clk = ~clk;

   encaps_if bus ();
   encaps_if bus2 ();

   encaps_sequencer dut (.clk(clk), .ovr_rst1(ovr_rst1), .ctl(bus));
   encaps_sequencer #(.RATE_WORDS(68), .FULL_BLOCKS(0), .LAST_WORDS(1), .PACK_BEATS(5))
      dut2 (.clk(clk), .ovr_rst1(ovr_rst1), .ctl(bus2));

   typedef struct {
      int   kind;   // 0 = hash_absorb, 1 = done
      int   at;
      logic lb;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   t0 = 0;
   int   n_chk = 0;
   int   n_err = 0;
   int   f1_cnt = 0, f2_cnt = 0, abs_cnt = 0, lb_cnt = 0;
   int   kd_cnt = 0;
   logic kd_resp = 1'b0;
   logic kd_stray = 1'b0;
   localparam int D = 24;

   assign bus.keccak_done = kd_resp | kd_stray;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_evt(input int kind);
      exp_t e;
      if (sb.size() == 0) begin
         n_chk++;
         n_err++;
         $display("FAIL unexpected_event: kind %0d at cycle %0d, expected none", kind, cyc - t0);
      end else begin
         e = sb.pop_front();
         chk("event_kind", kind, e.kind);
         chk("event_cycle", cyc - t0, e.at);
         chk("event_last_blk", int'(bus.last_blk), int'(e.lb));
         if (kind == 1) chk("k_load_with_done", int'(bus.k_load), 1);
      end
   endtask

   // Monitor: counts pulses and pops the scoreboard on every absorb/done
   initial begin
      forever begin
         @(negedge clk);
         if (bus.fifo1_en)    f1_cnt++;
         if (bus.fifo2_shift) f2_cnt++;
         if (bus.last_blk)    lb_cnt++;
         if (bus.hash_absorb) begin
            abs_cnt++;
            check_evt(0);
         end
         if (bus.done) check_evt(1);
      end
   end

   // Keccak model: completion pulse D cycles after each absorb
   initial begin
      forever begin
         @(negedge clk);
         kd_resp = 1'b0;
         if (ovr_rst1) begin
            kd_cnt = 0;
         end else begin
            if (kd_cnt > 0) begin
               kd_cnt--;
               if (kd_cnt == 0) kd_resp = 1'b1;
            end
            if (bus.hash_absorb) kd_cnt = D;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] out_vec();
      return {bus.rng_ready, bus.fifo1_en, bus.pack_clr, bus.pack_idx, bus.fifo2_shift,
              bus.fifo2_clr, bus.hash_init, bus.hash_absorb, bus.last_blk, bus.blk_idx,
              bus.k_load, bus.busy, bus.done};
   endfunction

   task automatic push(input int kind, input int at, input logic lb);
      exp_t e;
      e.kind = kind;
      e.at   = at;
      e.lb   = lb;
      sb.push_back(e);
   endtask

   task automatic expect_nominal(input int shift);
      push(0, 343 + shift, 1'b0);
      push(0, 709 + shift, 1'b0);
      push(0, 755 + shift, 1'b1);
      push(1, 780 + shift, 1'b1);
   endtask

   task automatic run_start();
      @(posedge clk);
      #1;
      f1_cnt  = 0;
      f2_cnt  = 0;
      abs_cnt = 0;
      lb_cnt  = 0;
      t0 = cyc;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // Called at posedge+1; returns at posedge+1 of relative cycle r
   task automatic wait_rel(input int r);
      int n;
      n = t0 + r - cyc;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int limit);
      int seen;
      seen = 0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (bus.done) begin
            seen = 1;
            break;
         end
      end
      chk("done_within_budget", seen, 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_run_counts(input string tag);
      chk({tag, "_fifo1_en_count"}, f1_cnt, 700);
      chk({tag, "_fifo2_shift_count"}, f2_cnt, 140);
      chk({tag, "_absorb_count"}, abs_cnt, 3);
      chk({tag, "_last_blk_cycles"}, lb_cnt, 26);
      chk({tag, "_scoreboard_drained"}, sb.size(), 0);
      chk({tag, "_busy_after"}, int'(bus.busy), 0);
   endtask

   initial begin
      int t2, rel, b2, a2n, a2, d2;
      logic lb2;
      bus.start = 1'b0;
      bus.rng_valid = 1'b0;
      bus2.start = 1'b0;
      bus2.rng_valid = 1'b0;
      bus2.keccak_done = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("por_outputs", int'(out_vec()), 0);
      ovr_rst1 = 1'b0;

      // Asynchronous reset in the middle of a FILL cycle
      bus.rng_valid = 1'b1;
      run_start();
      wait_rel(50);
      chk("pre_reset_rng_ready", int'(bus.rng_ready), 1);
      #1;
      ovr_rst1 = 1'b1;
      #1;
      chk("async_reset_outputs", int'(out_vec()), 0);
      chk("async_reset_busy", int'(bus.busy), 0);
      @(posedge clk);
      #1;
      ovr_rst1 = 1'b0;

      // Nominal run
      expect_nominal(0);
      run_start();
      wait_done(1000);
      check_run_counts("nominal");

      // RNG stall of 10 cycles at pack_idx = 3
      expect_nominal(10);
      run_start();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.pack_idx == 3'd2 && bus.rng_ready) break;
      end
      @(posedge clk);
      #1;
      bus.rng_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_pack_idx", int'(bus.pack_idx), 3);
         chk("stall_fifo1_en", int'(bus.fifo1_en), 0);
      end
      @(posedge clk);
      #1;
      bus.rng_valid = 1'b1;
      wait_done(1000);
      check_run_counts("stall");

      // Stray start / keccak_done
      expect_nominal(0);
      run_start();
      wait_rel(100);
      bus.start = 1'b1;
      wait_rel(101);
      bus.start = 1'b0;
      wait_rel(150);
      kd_stray = 1'b1;
      wait_rel(151);
      kd_stray = 1'b0;
      wait_rel(343);
      kd_stray = 1'b1;
      wait_rel(344);
      kd_stray = 1'b0;
      wait_done(1000);
      check_run_counts("stray");

      // Reset during WAIT of block 1, then a clean full run
      push(0, 343, 1'b0);
      push(0, 709, 1'b0);
      run_start();
      wait_rel(720);
      chk("wait_blk_idx", int'(bus.blk_idx), 1);
      #1;
      ovr_rst1 = 1'b1;
      #1;
      chk("midwait_reset_busy", int'(bus.busy), 0);
      chk("midwait_reset_blk_idx", int'(bus.blk_idx), 0);
      @(posedge clk);
      #1;
      ovr_rst1 = 1'b0;
      chk("midwait_absorbs", abs_cnt, 2);
      chk("midwait_scoreboard", sb.size(), 0);
      repeat (100) @(posedge clk);
      #1;
      expect_nominal(0);
      run_start();
      wait_rel(2);
      chk("restart_blk_idx", int'(bus.blk_idx), 0);
      wait_done(1000);
      check_run_counts("restart");

      // Variant: FULL_BLOCKS=0, LAST_WORDS=1
      b2 = 0;
      a2n = 0;
      a2 = -100;
      d2 = -1;
      lb2 = 1'b0;
      bus2.rng_valid = 1'b1;
      @(posedge clk);
      #1;
      t2 = cyc;
      bus2.start = 1'b1;
      @(posedge clk);
      #1;
      bus2.start = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         rel = cyc - t2;
         if (bus2.fifo1_en) b2++;
         if (bus2.hash_absorb) begin
            a2n++;
            a2 = rel;
            lb2 = bus2.last_blk;
         end
         if (bus2.done) d2 = rel;
         bus2.keccak_done = (a2n > 0) && (rel == a2 + D);
      end
      chk("variant_beats", b2, 5);
      chk("variant_absorbs", a2n, 1);
      chk("variant_last_blk", int'(lb2), 1);
      chk("variant_done_cycle", d2, 33);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
